// File: rtl/fmap_tx_pkg.sv
// Shared types and constants for the feature-map stream transmitter.
package fmap_tx_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fmap_tx_state_t;

    localparam int unsigned FMAP_DATA_W = 24;

endpackage

// File: rtl/fmap_tx_skid.sv
// Two-entry synchronous FIFO that absorbs the BRAM read latency so the
// stream can hold data steady while the sink is not ready.
module fmap_tx_skid #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] store [0:1];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store[0] <= '0;
            store[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = store[rd_ptr];
    assign empty = (count == 2'd0);

endmodule

// File: rtl/fmap_stream_tx.sv
// Reads one IMG_W x IMG_H frame from a 1-cycle-latency BRAM port and streams
// it raster-order over valid/ready. Define FMAP_TX_LAST_EN to add the
// o_data_last end-of-row marker.
module fmap_stream_tx
    import fmap_tx_pkg::*;
#(
    parameter  int unsigned IMG_W  = 32,
    parameter  int unsigned IMG_H  = 32,
    parameter  int unsigned DATA_W = FMAP_DATA_W,
    localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_intr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_data_ready
`ifdef FMAP_TX_LAST_EN
    ,
    output logic              o_data_last
`endif
);

`ifdef FMAP_TX_LAST_EN
    localparam int unsigned SKID_W = DATA_W + 1;
    localparam int unsigned COL_W  = $clog2(IMG_W);
`else
    localparam int unsigned SKID_W = DATA_W;
`endif

    fmap_tx_state_t    state;
    logic [ADDR_W-1:0] rd_addr;
    logic              inflight;
    logic              xfer;
    logic              issue;
    logic              last_addr;
    logic [1:0]        skid_count;
    logic              skid_empty;
    logic [SKID_W-1:0] skid_in;
    logic [SKID_W-1:0] skid_head;

    assign xfer      = o_data_valid & i_data_ready;
    assign last_addr = (rd_addr == ADDR_W'(IMG_W * IMG_H - 1));
    // A pop this cycle frees a slot, so issuing alongside a transfer cannot overflow the skid.
    assign issue     = (state == RUN) &&
                       ((({1'b0, skid_count} + {2'b00, inflight}) < 3'd2) || xfer);

    assign o_rd_en   = issue;
    assign o_rd_addr = rd_addr;

    // Frame sequencing with registered busy/interrupt flags.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_intr <= 1'b0;
        end else begin
            o_intr <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= RUN;
                        o_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && last_addr) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (skid_empty && !inflight) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_intr <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read address counter (wraps to 0 after the last pixel) and read-in-flight tracking.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_addr <= last_addr ? '0 : rd_addr + ADDR_W'(1);
            end
        end
    end

`ifdef FMAP_TX_LAST_EN
    logic [COL_W-1:0] col;
    logic             last_pend;

    // Column position is tracked at issue time and travels with the read as last_pend.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            col       <= '0;
            last_pend <= 1'b0;
        end else begin
            last_pend <= issue && (col == COL_W'(IMG_W - 1));
            if (issue) begin
                col <= (col == COL_W'(IMG_W - 1)) ? '0 : col + COL_W'(1);
            end
        end
    end

    assign skid_in     = {last_pend, i_rd_data};
    assign o_data      = skid_head[DATA_W-1:0];
    assign o_data_last = o_data_valid & skid_head[DATA_W];
`else
    assign skid_in     = i_rd_data;
    assign o_data      = skid_head;
`endif

    assign o_data_valid = !skid_empty;

    fmap_tx_skid #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk       (axi_clk),
        .rst_n     (axi_reset_n),
        .push      (inflight),
        .push_data (skid_in),
        .pop       (xfer),
        .head      (skid_head),
        .count     (skid_count),
        .empty     (skid_empty)
    );

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Self-checking bench for fmap_stream_tx (4x4 frame, random BRAM contents,
// several ready patterns, mid-frame start and reset).
module tb_fmap_stream_tx;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned DW   = 24;
    localparam int unsigned AW   = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, intr, rd_en, dvalid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] ddata;
    logic          dready = 1'b0;
`ifdef FMAP_TX_LAST_EN
    logic          dlast;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [0:NPIX-1];
    int  xfer_cnt, rd_cnt, intr_cnt;
    int  cyc = 0;
    int  first_cyc, last_cyc, intr_cyc;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    int  ready_mode = 0;
    int  phase = 0;
    logic [3:0] pat = 4'b1001;

    fmap_stream_tx #(
        .IMG_W  (W),
        .IMG_H  (H),
        .DATA_W (DW)
    ) dut (
        .axi_clk      (clk),
        .axi_reset_n  (rst_n),
        .i_start      (start),
        .o_busy       (busy),
        .o_intr       (intr),
        .o_rd_en      (rd_en),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_data_valid (dvalid),
        .o_data       (ddata),
        .i_data_ready (dready)
`ifdef FMAP_TX_LAST_EN
        ,
        .o_data_last  (dlast)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model with one-cycle read latency
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sink ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dready = 1'b1;
                1: begin dready = pat[phase % 4]; phase++; end
                2: dready = 1'($urandom_range(0, 1));
                default: dready = 1'b0;
            endcase
        end
    end

    // Stream monitor: every transfer is compared with the frame in raster order
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(dvalid), 32'd1);
                check("hold_data", 32'(ddata), 32'(prev_data));
            end
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(rd_cnt));
                rd_cnt++;
            end
            if (dvalid && dready) begin
                if (xfer_cnt < NPIX) check("pixel", 32'(ddata), 32'(mem[xfer_cnt]));
                else                 check("xfer_overrun", 32'(xfer_cnt), NPIX - 1);
`ifdef FMAP_TX_LAST_EN
                check("last", 32'(dlast), 32'((xfer_cnt % W) == W - 1));
`endif
                if (xfer_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfer_cnt++;
            end
            if (intr) begin
                intr_cnt++;
                intr_cyc = cyc;
                check("busy_at_intr", 32'(busy), 32'd0);
                check("xfers_at_intr", 32'(xfer_cnt), NPIX);
            end
            prev_stall = dvalid && !dready;
            prev_data  = ddata;
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
    endtask

    task automatic clear_counts();
        xfer_cnt = 0; rd_cnt = 0; intr_cnt = 0; phase = 0;
        first_cyc = 0; last_cyc = 0; intr_cyc = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_intr(input int limit);
        int n = 0;
        while (intr_cnt == 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (intr_cnt == 0) check("intr_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("intr_once", 32'(intr_cnt), 32'd1);
        check("frame_xfers", 32'(xfer_cnt), NPIX);
        check("frame_reads", 32'(rd_cnt), NPIX);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        clear_counts();
        fill_mem();
        #12;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_intr",  32'(intr), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_valid", 32'(dvalid), 32'd0);
        check("rst_addr",  32'(rd_addr), 32'd0);
        check("rst_data",  32'(ddata), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Frame 1: ready always high, latency and throughput
        ready_mode = 0;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("lat_c0", 32'(dvalid), 32'd0);
        @(posedge clk); #1 check("lat_c1", 32'(dvalid), 32'd0);
        @(posedge clk); #1 check("lat_c2", 32'(dvalid), 32'd1);
        check("first_pixel", 32'(ddata), 32'(mem[0]));
        wait_intr(200);
        check("back_to_back", 32'(last_cyc - first_cyc), NPIX - 1);
        check("intr_latency", 32'(intr_cyc - last_cyc), 32'd2);

        // Frame 2: ready pattern 1,0,0,1
        clear_counts(); fill_mem(); ready_mode = 1;
        pulse_start();
        wait_intr(400);

        // Frame 3: random ready with a start pulse mid-frame
        clear_counts(); fill_mem(); ready_mode = 2;
        pulse_start();
        repeat (3 + $urandom_range(0, 6)) @(posedge clk);
        #1 check("busy_mid_frame", 32'(busy), 32'd1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_intr(400);

        // Frame 4: ready held low for 50 cycles
        clear_counts(); fill_mem(); ready_mode = 3;
        pulse_start();
        repeat (50) @(posedge clk);
        #1;
        check("stall_reads", 32'(rd_cnt), 32'd2);
        check("stall_valid", 32'(dvalid), 32'd1);
        check("stall_data", 32'(ddata), 32'(mem[0]));
        check("stall_no_intr", 32'(intr_cnt), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        ready_mode = 0;
        wait_intr(200);

        // Frame 5: reset after the 7th transfer, then a fresh frame
        clear_counts(); fill_mem(); ready_mode = 2;
        pulse_start();
        begin
            int n = 0;
            while (xfer_cnt < 7 && n < 300) begin
                @(posedge clk);
                n++;
            end
            check("reach_7_xfers", 32'(xfer_cnt), 32'd7);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy",  32'(busy), 32'd0);
        check("mrst_rd_en", 32'(rd_en), 32'd0);
        check("mrst_valid", 32'(dvalid), 32'd0);
        check("mrst_addr",  32'(rd_addr), 32'd0);
        check("mrst_data",  32'(ddata), 32'd0);
        check("mrst_no_intr", 32'(intr_cnt), 32'd0);
        repeat (2) @(posedge clk);
        clear_counts(); fill_mem();
        @(negedge clk); rst_n = 1'b1;
        ready_mode = 0;
        pulse_start();
        wait_intr(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
